// File: rtl/dma_streamer.sv
// Cuts one read descriptor into AXI-legal burst requests: 4 KB safe, MAX_BEATS capped,
// unaligned head/tail bytes split off as single-beat strobed requests.
module dma_streamer #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BEATS  = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    dma_go_i,
  input  logic                    dma_abort_i,
  input  logic [ADDR_WIDTH-1:0]   desc_addr_i,
  input  logic [31:0]             desc_num_bytes_i,
  input  logic                    desc_mode_i,
  output logic                    req_valid_o,
  output logic [ADDR_WIDTH-1:0]   req_addr_o,
  output logic [7:0]              req_alen_o,
  output logic [2:0]              req_size_o,
  output logic [DATA_WIDTH/8-1:0] req_strb_o,
  output logic                    req_mode_o,
  input  logic                    req_ready_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o
);
  localparam int          BYTES       = DATA_WIDTH / 8;
  localparam int          OFFW        = $clog2(BYTES);
  localparam logic [31:0] BYTES_U     = 32'(BYTES);
  localparam logic [31:0] MAX_BEATS_U = 32'(MAX_BEATS);

  typedef enum logic [1:0] {IDLE, CALC, REQ, DONE} state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] cur_addr_q;
  logic [31:0]           bytes_left_q;
  logic [31:0]           req_n_q;
  logic                  mode_q;
  logic                  abort_pend_q;
  logic                  req_valid_q;
  logic [ADDR_WIDTH-1:0] req_addr_q;
  logic [7:0]            req_alen_q;
  logic [2:0]            req_size_q;
  logic [BYTES-1:0]      req_strb_q;
  logic                  req_mode_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  err_q;

  logic [31:0]           off_d;
  logic [31:0]           left_beats_d;
  logic [31:0]           room_4k_d;
  logic [31:0]           beats_d;
  logic [31:0]           req_n_d;
  logic [7:0]            req_alen_d;
  logic [BYTES-1:0]      req_strb_d;
  logic                  head_d;

  // Next request geometry, derived from the current cursor while in CALC.
  always_comb begin
    off_d        = 32'(cur_addr_q[OFFW-1:0]);
    head_d       = (off_d != 32'd0) || (bytes_left_q < BYTES_U);
    left_beats_d = bytes_left_q >> OFFW;
    room_4k_d    = (32'd4096 - 32'(cur_addr_q[11:0])) >> OFFW;
    beats_d      = left_beats_d;
    if (mode_q) begin
      if (beats_d > 32'd16) beats_d = 32'd16;
    end else begin
      if (beats_d > MAX_BEATS_U) beats_d = MAX_BEATS_U;
      if (beats_d > room_4k_d)   beats_d = room_4k_d;
    end
    req_n_d    = beats_d << OFFW;
    req_alen_d = 8'(beats_d - 32'd1);
    req_strb_d = '1;
    if (head_d) begin
      req_n_d    = BYTES_U - off_d;
      if (bytes_left_q < req_n_d) req_n_d = bytes_left_q;
      req_alen_d = 8'd0;
      for (int i = 0; i < BYTES; i++) begin
        req_strb_d[i] = ($unsigned(i) >= off_d) && ($unsigned(i) < off_d + req_n_d);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      cur_addr_q   <= '0;
      bytes_left_q <= '0;
      req_n_q      <= '0;
      mode_q       <= 1'b0;
      abort_pend_q <= 1'b0;
      req_valid_q  <= 1'b0;
      req_addr_q   <= '0;
      req_alen_q   <= '0;
      req_size_q   <= 3'(OFFW);
      req_strb_q   <= '0;
      req_mode_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (dma_go_i) begin
            cur_addr_q   <= desc_addr_i;
            bytes_left_q <= desc_num_bytes_i;
            mode_q       <= desc_mode_i;
            abort_pend_q <= 1'b0;
            err_q        <= 1'b0;
            busy_q       <= 1'b1;
            if (desc_num_bytes_i == 32'd0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else if (desc_mode_i && ((desc_addr_i[OFFW-1:0] != '0) ||
                                         (desc_num_bytes_i[OFFW-1:0] != '0))) begin
              err_q   <= 1'b1;
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          if (dma_abort_i) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            req_addr_q  <= {cur_addr_q[ADDR_WIDTH-1:OFFW], {OFFW{1'b0}}};
            req_alen_q  <= req_alen_d;
            req_strb_q  <= req_strb_d;
            req_mode_q  <= mode_q;
            req_n_q     <= req_n_d;
            req_valid_q <= 1'b1;
            state_q     <= REQ;
          end
        end
        REQ: begin
          // A request already on the bus is never withdrawn; abort waits for the handshake.
          if (dma_abort_i) abort_pend_q <= 1'b1;
          if (req_ready_i) begin
            req_valid_q  <= 1'b0;
            bytes_left_q <= bytes_left_q - req_n_q;
            if (!mode_q) cur_addr_q <= cur_addr_q + ADDR_WIDTH'(req_n_q);
            if ((bytes_left_q == req_n_q) || abort_pend_q || dma_abort_i) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= CALC;
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_valid_o = req_valid_q;
  assign req_addr_o  = req_addr_q;
  assign req_alen_o  = req_alen_q;
  assign req_size_o  = req_size_q;
  assign req_strb_o  = req_strb_q;
  assign req_mode_o  = req_mode_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
endmodule

// File: tb/tb_dma_streamer.sv
// Randomized and directed bench for dma_streamer against a descriptor-splitting reference model.
module tb_dma_streamer;
  logic        clk = 1'b0;
  logic        rst;
  logic        dma_go_i;
  logic        dma_abort_i;
  logic [31:0] desc_addr_i;
  logic [31:0] desc_num_bytes_i;
  logic        desc_mode_i;
  logic        req_valid_o;
  logic [31:0] req_addr_o;
  logic [7:0]  req_alen_o;
  logic [2:0]  req_size_o;
  logic [3:0]  req_strb_o;
  logic        req_mode_o;
  logic        req_ready_i;
  logic        busy_o;
  logic        done_o;
  logic        err_o;

  always #5 clk = ~clk;

  dma_streamer #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_BEATS(256)) dut (
    .clk(clk), .rst(rst),
    .dma_go_i(dma_go_i), .dma_abort_i(dma_abort_i),
    .desc_addr_i(desc_addr_i), .desc_num_bytes_i(desc_num_bytes_i), .desc_mode_i(desc_mode_i),
    .req_valid_o(req_valid_o), .req_addr_o(req_addr_o), .req_alen_o(req_alen_o),
    .req_size_o(req_size_o), .req_strb_o(req_strb_o), .req_mode_o(req_mode_o),
    .req_ready_i(req_ready_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  alen;
    logic [3:0]  strb;
  } req_t;

  req_t exp_q[$];
  bit   exp_err;

  // Split a descriptor into the list of bursts it must produce (4-byte bus).
  task automatic build_model(input logic [31:0] a_in, input logic [31:0] n, input bit fixed);
    longint unsigned a, left, off, nb, beats;
    req_t r;
    exp_q.delete();
    exp_err = 0;
    a = a_in;
    left = n;
    if (n == 0) return;
    if (fixed && ((a % 4) != 0 || (n % 4) != 0)) begin
      exp_err = 1;
      return;
    end
    while (left > 0) begin
      off = a % 4;
      if (off != 0 || left < 4) begin
        nb = 4 - off;
        if (left < nb) nb = left;
        r.alen = 0;
        r.strb = 4'(((1 << nb) - 1) << off);
      end else begin
        beats = left / 4;
        if (fixed) begin
          if (beats > 16) beats = 16;
        end else begin
          if (beats > 256) beats = 256;
          if (beats > (4096 - (a % 4096)) / 4) beats = (4096 - (a % 4096)) / 4;
        end
        nb = beats * 4;
        r.alen = 8'(beats - 1);
        r.strb = 4'hF;
      end
      r.addr = 32'(a - off);
      exp_q.push_back(r);
      left -= nb;
      if (!fixed) a = (a + nb) % 64'h1_0000_0000;
    end
  endtask

  task automatic run_desc(input logic [31:0] a, input logic [31:0] n, input bit fixed,
                          input int pct, input int stall, input int abort_at, input int max_hs);
    int   cyc, hs, last_hs, first_vld, stall_left, exp_done;
    bit   done_seen, prev_vld, prev_hs, mode_now;
    req_t prev, e;
    build_model(a, n, fixed);
    if (max_hs >= 0) while (exp_q.size() > max_hs) void'(exp_q.pop_back());
    @(negedge clk);
    dma_go_i = 1'b1; desc_addr_i = a; desc_num_bytes_i = n; desc_mode_i = fixed;
    dma_abort_i = 1'b0; req_ready_i = 1'b0;
    mode_now = fixed;
    cyc = 0; hs = 0; last_hs = -10; first_vld = -1; stall_left = stall;
    done_seen = 0; prev_vld = 0; prev_hs = 0;
    prev = '{default: '0};
    while (!done_seen && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      dma_go_i = 1'b0;
      dma_abort_i = (cyc == abort_at);
      if (prev_hs) check("vld_drop_after_hs", req_valid_o, 0);
      if (prev_vld && !prev_hs && req_valid_o)
        check("stall_stable", {req_addr_o, req_alen_o, req_strb_o}, {prev.addr, prev.alen, prev.strb});
      if (req_valid_o && first_vld < 0) begin
        first_vld = cyc;
        check("start_latency", cyc, 2);
      end
      if (done_o) begin
        done_seen = 1;
        exp_done = (hs > 0) ? last_hs + 1 : ((abort_at == 1) ? 2 : 1);
        check("done_cycle", cyc, exp_done);
        check("busy_at_done", busy_o, 1);
        check("err_at_done", err_o, exp_err);
        check("hs_count", hs, hs + exp_q.size());
        break;
      end
      if (cyc == 3) begin
        // Must be ignored: the block is not idle here.
        dma_go_i = 1'b1; desc_addr_i = $urandom; desc_num_bytes_i = 32'd4; desc_mode_i = 1'b0;
      end
      if (req_valid_o && stall_left > 0) begin
        req_ready_i = 1'b0;
        stall_left--;
      end else begin
        req_ready_i = ($urandom_range(0, 99) < pct);
      end
      if (req_valid_o && req_ready_i) begin
        if (exp_q.size() == 0) begin
          check("unexpected_req", req_addr_o, 64'hDEAD);
        end else begin
          e = exp_q.pop_front();
          check("req_addr", req_addr_o, e.addr);
          check("req_alen", req_alen_o, e.alen);
          check("req_strb", req_strb_o, e.strb);
          check("req_mode", req_mode_o, mode_now);
          check("req_size", req_size_o, 2);
        end
        hs++;
        last_hs = cyc;
      end
      prev_vld = req_valid_o;
      prev_hs = req_valid_o && req_ready_i;
      prev.addr = req_addr_o; prev.alen = req_alen_o; prev.strb = req_strb_o;
    end
    if (!done_seen) check("done_timeout", 0, 1);
    @(negedge clk);
    dma_go_i = 1'b0; dma_abort_i = 1'b0; req_ready_i = 1'b0;
    check("busy_low_idle", busy_o, 0);
    check("done_one_cycle", done_o, 0);
    check("err_held", err_o, exp_err);
  endtask

  initial begin
    logic [31:0] a, n;
    bit          fx;
    rst = 1'b0; dma_go_i = 1'b0; dma_abort_i = 1'b0; req_ready_i = 1'b0;
    desc_addr_i = '0; desc_num_bytes_i = '0; desc_mode_i = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", req_valid_o, 0);
    check("rst_addr", req_addr_o, 0);
    check("rst_alen", req_alen_o, 0);
    check("rst_strb", req_strb_o, 0);
    check("rst_mode", req_mode_o, 0);
    check("rst_size", req_size_o, 2);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_err", err_o, 0);
    rst = 1'b1;
    @(negedge clk);

    run_desc(32'h1000, 64, 0, 100, 0, -1, -1);
    run_desc(32'h0FF0, 32, 0, 100, 0, -1, -1);
    run_desc(32'h2002, 9, 0, 100, 0, -1, -1);
    run_desc(32'h3001, 2, 0, 100, 0, -1, -1);
    run_desc(32'h0, 2048, 0, 100, 0, -1, -1);
    run_desc(32'h0, 256, 0, 100, 5, 3, 1);
    run_desc(32'h4002, 8, 1, 100, 0, -1, -1);
    run_desc(32'h4000, 128, 1, 100, 0, -1, -1);
    run_desc(32'h5000, 0, 0, 100, 0, -1, -1);
    run_desc(32'h6000, 64, 0, 100, 0, 1, 0);
    run_desc(32'hFFFF_FFF8, 16, 0, 60, 0, -1, -1);

    for (int t = 0; t < 40; t++) begin
      fx = ($urandom_range(0, 3) == 0);
      a  = $urandom;
      if ($urandom_range(0, 1) == 1) a[11:0] = 12'hFFF - 12'($urandom_range(0, 40));
      n  = $urandom_range(1, 2500);
      if (fx && $urandom_range(0, 3) != 0) begin
        a[1:0] = 2'b00;
        n[1:0] = 2'b00;
      end
      run_desc(a, n, fx, $urandom_range(30, 100), $urandom_range(0, 3), -1, -1);
    end

    // Reset while a request is pending.
    @(negedge clk);
    dma_go_i = 1'b1; desc_addr_i = 32'h7000; desc_num_bytes_i = 32'd64; desc_mode_i = 1'b0;
    @(negedge clk);
    dma_go_i = 1'b0;
    @(negedge clk);
    check("pre_rst_valid", req_valid_o, 1);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", req_valid_o, 0);
    check("mid_rst_busy", busy_o, 0);
    rst = 1'b1;
    run_desc(32'h7000, 20, 0, 100, 0, -1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dma_streamer.md
# dma_streamer

Read-side descriptor streamer feeding the read request port of the DMA AXI master interface (`dma_axi_rd_req_i` / `dma_axi_rd_resp_o`). It takes one transfer descriptor (start address, byte count, burst mode) from the DMA FSM and cuts it into AXI-legal burst requests. Every request respects the 4 KB boundary and the maximum burst length. Each request carries one byte-strobe mask that the AXI interface applies to every beat of that burst, so unaligned head and tail bytes are always issued as separate single-beat requests.

## Interface
- `ADDR_WIDTH`, 32, address width.
- `DATA_WIDTH`, 32, AXI data width. Power of two, at least 32. BYTES = DATA_WIDTH/8.
- `MAX_BEATS`, 256, maximum beats per INCR burst (1..256).
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-low.
- `dma_go_i`  in  1  single-cycle start pulse; sampled only in IDLE.
- `dma_abort_i`  in  1  abort request (level).
- `desc_addr_i`  in  ADDR_WIDTH  start byte address.
- `desc_num_bytes_i`  in  32  byte count.
- `desc_mode_i`  in  1  0 = INCR, 1 = FIXED.
- `req_valid_o`  out  1  request valid.
- `req_addr_o`  out  ADDR_WIDTH  burst start address, always BYTES-aligned.
- `req_alen_o`  out  8  beats − 1.
- `req_size_o`  out  3  log2(BYTES).
- `req_strb_o`  out  BYTES  byte mask applied to every beat of the burst.
- `req_mode_o`  out  1  copy of the latched mode.
- `req_ready_i`  in  1  request accepted (the AXI address handshake).
- `busy_o`  out  1  high in every state except IDLE.
- `done_o`  out  1  one-cycle completion pulse.
- `err_o`  out  1  descriptor error, held until the next accepted `dma_go_i`.

## Operation
- States: IDLE, CALC, REQ, DONE. All outputs are registered.
- IDLE, on `dma_go_i`:
  - Latch the address as `cur_addr`, the byte count as `bytes_left`, and the mode.
  - Clear `err_o`.
  - If the byte count is 0, go to DONE.
  - If mode is FIXED and either the address or the byte count is not a multiple of BYTES, set `err_o` and go to DONE.
  - Otherwise go to CALC.
- CALC: compute the next request and load the `req_*` registers, with `off` = `cur_addr[log2(BYTES)-1:0]`.
  - **Head/single**, when `off` ≠ 0 or `bytes_left` < BYTES:
    - n = min(BYTES − `off`, `bytes_left`); alen = 0.
    - `req_strb_o` bits [off, off+n−1] set, all others clear.
  - **Body**, otherwise:
    - beats = min(floor(`bytes_left`/BYTES), `MAX_BEATS`, (4096 − `cur_addr`[11:0])/BYTES). FIXED mode uses min(floor(`bytes_left`/BYTES), 16) instead.
    - alen = beats − 1; strb = all ones; n = beats·BYTES.
  - `req_addr_o` = `cur_addr` with the low log2(BYTES) bits cleared.
  - Then go to REQ.
- REQ:
  - `req_valid_o` = 1. All `req_*` fields hold stable until `req_ready_i`.
  - On handshake:
    - `bytes_left` −= n.
    - INCR: `cur_addr` += n. FIXED: `cur_addr` is unchanged.
    - `req_valid_o` drops in the next cycle.
    - If `bytes_left` is now 0, or an abort is pending, go to DONE; otherwise go to CALC.
- DONE: `done_o` = 1 for exactly one cycle, then go to IDLE.
- Abort:
  - In CALC, go straight to DONE without issuing a request.
  - In REQ, `req_valid_o` is never withdrawn before the handshake. Abort is latched (`abort_pend`) and honoured right after the handshake.
  - Ignored in IDLE.
- Arithmetic: `bytes_left` is 32 bits. `cur_addr` wraps modulo 2^ADDR_WIDTH, with no error.

## Timing
- Reset values: `req_valid_o` = 0; `req_addr_o`, `req_alen_o`, `req_strb_o`, `req_mode_o` = 0; `req_size_o` = log2(BYTES); `busy_o`, `done_o`, `err_o` = 0. State = IDLE. Reset mid-transfer drops `req_valid_o` in the next cycle.
- Start latency: `dma_go_i` at cycle 0 → CALC at cycle 1 → `req_valid_o` at cycle 2.
- Throughput: handshake at cycle t → next `req_valid_o` at t+2, so at most one request every 2 cycles.
- Last handshake at cycle t → `done_o` at t+1 → IDLE at t+2. `busy_o` is low from t+2.
- Zero-byte or error descriptor: `done_o` at cycle 1. `err_o` is visible from cycle 1.
- `dma_go_i` outside IDLE is ignored.

## Test plan
- INCR, addr 0x1000, 64 B, ready tied high → one request {0x1000, alen 15, strb 0xF}; `done_o` 1 cycle after the handshake.
- 4 KB split, addr 0x0FF0, 32 B → {0x0FF0, alen 3, strb 0xF} then {0x1000, alen 3, strb 0xF}.
- Unaligned, addr 0x2002, 9 B → {0x2000, alen 0, strb 0xC}, {0x2004, alen 0, strb 0xF}, {0x2008, alen 0, strb 0x7}. Also addr 0x3001, 2 B → a single request {0x3000, alen 0, strb 0x6}.
- Max burst, addr 0x0, 2048 B → {0x000, alen 255} and {0x400, alen 255}, both strb 0xF.
- Backpressure plus abort: 256 B at 0x0, `req_ready_i` low for 5 cycles, `dma_abort_i` pulsed in the 2nd stall cycle → first request fields stable for all stall cycles, exactly one handshake, no further requests, then `done_o`.
- FIXED, addr 0x4002, 8 B → `err_o` = 1, no `req_valid_o`, `done_o` at cycle 1. FIXED, addr 0x4000, 128 B → {0x4000, alen 15} twice, same address.
